// File: rtl/dbg_reg_master.sv
// Debug register master: turns status/read/write/control commands into core register
// accesses, gated by a halt request that must settle before GPRs may be touched.
module dbg_reg_master #(
    parameter int unsigned HALT_SETTLE_CYCLES = 4,
    parameter int unsigned RESET_PULSE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [4:0]  cmd_addr_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic [4:0]  jtag_reg_addr_o,
    output logic [31:0] jtag_reg_data_o,
    output logic        jtag_reg_we_o,
    input  logic [31:0] jtag_reg_data_i,
    output logic        jtag_halt_flag_o,
    output logic        jtag_reset_flag_o
);

    typedef enum logic [2:0] {StIdle, StRead, StWrite, StRstp, StResp} state_e;

    localparam logic [7:0] SettleMax = 8'(HALT_SETTLE_CYCLES);
    localparam logic [7:0] PulseLast = 8'(RESET_PULSE_CYCLES - 1);

    localparam logic [1:0] OpStatus  = 2'b00;
    localparam logic [1:0] OpRead    = 2'b01;
    localparam logic [1:0] OpWrite   = 2'b10;
    localparam logic [1:0] OpControl = 2'b11;

    state_e      r_state;
    logic        r_halt;
    logic [7:0]  r_settle_cnt;
    logic [7:0]  r_pulse_cnt;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;
    logic [4:0]  r_reg_addr;
    logic [31:0] r_reg_data;
    logic        r_reg_we;
    logic        r_reset_flag;

    logic        w_accept;
    logic        w_halt_d;
    logic [7:0]  w_settle_cnt_d;
    logic        w_settled;
    logic        w_settled_d;
    logic [31:0] w_status;

    assign w_accept = cmd_valid_i & r_cmd_ready;
    assign w_halt_d = (w_accept && cmd_op_i == OpControl) ? cmd_data_i[0] : r_halt;

    // Counting begins on the edge after halt rises; any cycle with halt low clears it.
    always_comb begin
        w_settle_cnt_d = 8'd0;
        if (r_halt && w_halt_d) begin
            w_settle_cnt_d = (r_settle_cnt == SettleMax) ? r_settle_cnt : r_settle_cnt + 8'd1;
        end
    end

    assign w_settled   = r_halt && (r_settle_cnt == SettleMax);
    assign w_settled_d = w_halt_d && (w_settle_cnt_d == SettleMax);
    // Status reflects the values that become visible on the edge that enters RESP.
    assign w_status    = {30'b0, w_settled_d, w_halt_d};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_halt       <= 1'b0;
            r_settle_cnt <= 8'd0;
            r_pulse_cnt  <= 8'd0;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= 32'd0;
            r_rsp_err    <= 1'b0;
            r_reg_addr   <= 5'd0;
            r_reg_data   <= 32'd0;
            r_reg_we     <= 1'b0;
            r_reset_flag <= 1'b0;
        end else begin
            r_halt       <= w_halt_d;
            r_settle_cnt <= w_settle_cnt_d;
            r_reg_we     <= 1'b0;
            r_reg_addr   <= 5'd0;
            r_reg_data   <= 32'd0;

            unique case (r_state)
                StIdle: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        unique case (cmd_op_i)
                            OpRead, OpWrite: begin
                                if (!w_settled) begin
                                    r_rsp_data  <= 32'd0;
                                    r_rsp_err   <= 1'b1;
                                    r_rsp_valid <= 1'b1;
                                    r_state     <= StResp;
                                end else if (cmd_op_i == OpRead) begin
                                    r_reg_addr <= cmd_addr_i;
                                    r_state    <= StRead;
                                end else begin
                                    r_reg_addr <= cmd_addr_i;
                                    r_reg_data <= cmd_data_i;
                                    r_reg_we   <= 1'b1;
                                    r_state    <= StWrite;
                                end
                            end
                            OpControl: begin
                                if (cmd_data_i[1]) begin
                                    r_reset_flag <= 1'b1;
                                    r_pulse_cnt  <= PulseLast;
                                    r_state      <= StRstp;
                                end else begin
                                    r_rsp_data  <= w_status;
                                    r_rsp_err   <= 1'b0;
                                    r_rsp_valid <= 1'b1;
                                    r_state     <= StResp;
                                end
                            end
                            default: begin
                                r_rsp_data  <= w_status;
                                r_rsp_err   <= 1'b0;
                                r_rsp_valid <= 1'b1;
                                r_state     <= StResp;
                            end
                        endcase
                    end
                end
                StRead: begin
                    r_rsp_data  <= jtag_reg_data_i;
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= StResp;
                end
                StWrite: begin
                    r_rsp_data  <= 32'd0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= StResp;
                end
                StRstp: begin
                    if (r_pulse_cnt == 8'd0) begin
                        r_reset_flag <= 1'b0;
                        r_rsp_data   <= w_status;
                        r_rsp_err    <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= StResp;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt - 8'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready_o       = r_cmd_ready;
    assign rsp_valid_o       = r_rsp_valid;
    assign rsp_data_o        = r_rsp_data;
    assign rsp_err_o         = r_rsp_err;
    assign jtag_reg_addr_o   = r_reg_addr;
    assign jtag_reg_data_o   = r_reg_data;
    assign jtag_reg_we_o     = r_reg_we;
    assign jtag_halt_flag_o  = r_halt;
    assign jtag_reset_flag_o = r_reset_flag;

endmodule

// File: tb/tb_dbg_reg_master.sv
// Bench for dbg_reg_master: directed scenarios plus random command traffic, scored against a
// transaction-level model of halt/settle timing and a shadow copy of the core register file.
module tb_dbg_reg_master;

    localparam int SETTLE = 4;
    localparam int PULSE  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [4:0]  cmd_addr_i;
    logic [31:0] cmd_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic [4:0]  jtag_reg_addr_o;
    logic [31:0] jtag_reg_data_o;
    logic        jtag_reg_we_o;
    logic [31:0] jtag_reg_data_i;
    logic        jtag_halt_flag_o;
    logic        jtag_reset_flag_o;

    dbg_reg_master #(
        .HALT_SETTLE_CYCLES (SETTLE),
        .RESET_PULSE_CYCLES (PULSE)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_valid_i       (cmd_valid_i),
        .cmd_ready_o       (cmd_ready_o),
        .cmd_op_i          (cmd_op_i),
        .cmd_addr_i        (cmd_addr_i),
        .cmd_data_i        (cmd_data_i),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_ready_i       (rsp_ready_i),
        .rsp_data_o        (rsp_data_o),
        .rsp_err_o         (rsp_err_o),
        .jtag_reg_addr_o   (jtag_reg_addr_o),
        .jtag_reg_data_o   (jtag_reg_data_o),
        .jtag_reg_we_o     (jtag_reg_we_o),
        .jtag_reg_data_i   (jtag_reg_data_i),
        .jtag_halt_flag_o  (jtag_halt_flag_o),
        .jtag_reset_flag_o (jtag_reset_flag_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core register file seen by the DUT
    logic [31:0] core_mem [32];
    always @(posedge clk) if (jtag_reg_we_o) core_mem[jtag_reg_addr_o] <= jtag_reg_data_o;
    assign jtag_reg_data_i = core_mem[jtag_reg_addr_o];

    int          we_cnt = 0;
    logic [4:0]  we_addr;
    logic [31:0] we_data;
    always @(negedge clk) begin
        if (jtag_reg_we_o) begin
            we_cnt  = we_cnt + 1;
            we_addr = jtag_reg_addr_o;
            we_data = jtag_reg_data_o;
        end
    end

    // Reference model state
    bit          m_halt = 1'b0;
    int          m_halt_edge = 0;
    logic [31:0] mdl_regs [32];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Halt has been high for at least SETTLE edges by edge e (counted from the rising edge).
    function automatic logic [31:0] m_status(input int e);
        logic s;
        s = m_halt && ((e - m_halt_edge) >= SETTLE);
        return {30'b0, s, m_halt};
    endfunction

    task automatic run_cmd(input logic [1:0] op, input logic [4:0] addr,
                           input logic [31:0] data, input int hold);
        int          t, lat, budget, flag_cyc, we0, exp_lat, exp_we, exp_flag;
        logic [31:0] exp_data;
        logic        exp_err;
        bit          settled;
        logic [34:0] snap;
        @(negedge clk);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_addr_i  = addr;
        cmd_data_i  = data;
        budget = 0;
        while (!cmd_ready_o && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready_o) begin
            check_eq("accept_timeout", 0, 1);
            cmd_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        t   = cyc;
        we0 = we_cnt;

        settled  = m_halt && ((t - m_halt_edge) >= SETTLE + 1);
        exp_err  = 1'b0;
        exp_data = 32'd0;
        exp_we   = 0;
        exp_flag = 0;
        exp_lat  = 1;
        case (op)
            2'b00: exp_data = m_status(t);
            2'b01, 2'b10: begin
                if (!settled) begin
                    exp_err = 1'b1;
                end else if (op == 2'b01) begin
                    exp_lat  = 2;
                    exp_data = mdl_regs[addr];
                end else begin
                    exp_lat       = 2;
                    exp_we        = 1;
                    mdl_regs[addr] = data;
                end
            end
            default: begin
                if (data[0] && !m_halt) m_halt_edge = t;
                m_halt = data[0];
                if (data[1]) begin
                    exp_lat  = PULSE + 1;
                    exp_flag = PULSE;
                end
                exp_data = m_status(t + exp_lat - 1);
            end
        endcase

        // While busy, throw garbage at the command port; it must be ignored.
        lat      = 0;
        flag_cyc = 0;
        do begin
            @(negedge clk);
            lat++;
            if (jtag_reset_flag_o) flag_cyc++;
            if (!rsp_valid_o) begin
                cmd_valid_i = 1'($urandom_range(0, 1));
                cmd_op_i    = 2'($urandom);
                cmd_addr_i  = 5'($urandom);
                cmd_data_i  = $urandom;
            end
        end while (!rsp_valid_o && lat < 20);

        check_eq("latency", 64'(lat), 64'(exp_lat));
        check_eq("rst_pulse_width", 64'(flag_cyc), 64'(exp_flag));
        check_eq("rsp_data", rsp_data_o, exp_data);
        check_eq("rsp_err", rsp_err_o, exp_err);
        check_eq("we_pulses", 64'(we_cnt - we0), 64'(exp_we));
        if (exp_we == 1) check_eq("we_addr_data", {we_addr, we_data}, {addr, data});
        check_eq("halt_flag", jtag_halt_flag_o, m_halt);

        snap = {rsp_valid_o, cmd_ready_o, rsp_err_o, rsp_data_o};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cmd_valid_i = 1'($urandom_range(0, 1));
            check_eq("rsp_hold", {rsp_valid_o, cmd_ready_o, rsp_err_o, rsp_data_o}, snap);
        end
        rsp_ready_i = 1'b1;
        cmd_valid_i = 1'b0;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        check_eq("post_rsp", {rsp_valid_o, cmd_ready_o, jtag_reg_we_o, jtag_reg_addr_o,
                 jtag_reg_data_o}, {3'b010, 5'd0, 32'd0});
    endtask

    initial begin
        rst         = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 2'b00;
        cmd_addr_i  = 5'd0;
        cmd_data_i  = 32'd0;
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            core_mem[i] = $urandom;
            mdl_regs[i] = core_mem[i];
        end
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o,
                 jtag_reg_we_o, jtag_halt_flag_o, jtag_reset_flag_o}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("ready_after_reset", cmd_ready_o, 1'b1);

        // Directed scenarios
        run_cmd(2'b00, 5'd0, 32'd0, 0);
        run_cmd(2'b01, 5'd5, 32'd0, 0);
        run_cmd(2'b11, 5'd0, 32'h1, 0);
        repeat (4) @(negedge clk);
        run_cmd(2'b10, 5'd3, 32'hDEADBEEF, 0);
        run_cmd(2'b01, 5'd3, 32'd0, 0);
        check_eq("read_back_literal", rsp_data_o, 32'hDEADBEEF);
        run_cmd(2'b11, 5'd0, 32'h0, 0);
        run_cmd(2'b11, 5'd0, 32'h3, 0);
        run_cmd(2'b11, 5'd0, 32'h1, 0);
        repeat (6) @(negedge clk);
        run_cmd(2'b01, 5'd3, 32'd0, 5);

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            logic [1:0]  op;
            logic [31:0] d;
            op = 2'($urandom);
            d  = $urandom;
            if (op == 2'b11) begin
                d[0] = ($urandom_range(0, 3) != 0);
                d[1] = ($urandom_range(0, 9) < 3);
            end
            run_cmd(op, 5'($urandom), d, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        // Reset asserted in the middle of a reset pulse
        @(negedge clk);
        cmd_valid_i = 1'b1;
        cmd_op_i    = 2'b11;
        cmd_data_i  = 32'h3;
        check_eq("rstp_ready", cmd_ready_o, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check_eq("rstp_flag_on", {jtag_reset_flag_o, jtag_halt_flag_o}, 2'b11);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rstp_abort", {jtag_reset_flag_o, jtag_halt_flag_o, cmd_ready_o}, 3'b000);
        m_halt = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            repeat (10) begin
                @(negedge clk);
                seen = seen | rsp_valid_o;
            end
            check_eq("no_rsp_after_abort", seen, 1'b0);
        end
        check_eq("ready_after_abort", cmd_ready_o, 1'b1);
        run_cmd(2'b00, 5'd0, 32'd0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
